// File: rtl/gray_vector_sequencer_pkg.sv
// Shared types and helpers for the Gray-order truth-table sequencer.
package gray_seq_pkg;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [VEC_W-1:0] bin2gray(input logic [VEC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_vector_sequencer_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last cycle of each dwell.
module dwell_timer
    import gray_seq_pkg::*;
#(
    parameter int unsigned DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_c = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = expire_c ? '0 : CNT_W'(cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gray_vector_sequencer.sv
// Walks all 16 input vectors in Gray order, captures z into a truth table and
// compares it against EXPECT.
module gray_vector_sequencer
    import gray_seq_pkg::*;
#(
    parameter int unsigned       DWELL  = 20,
    parameter logic [N_VEC-1:0]  EXPECT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] truth,
    output logic [N_VEC-1:0] mismatch
);

    localparam logic [VEC_W-1:0] LAST_STEP = VEC_W'(N_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   step_q, step_d;
    logic [N_VEC-1:0]   truth_q, truth_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               tmr_clear;
    logic               tmr_en;
    logic               expire;

    dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .expire_c (expire)
    );

    // Next-state, vector stepping and truth capture
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        step_d    = step_q;
        truth_d   = truth_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    vec_d     = '0;
                    step_d    = '0;
                    truth_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    tmr_clear = 1'b1;
                end
            end
            RUN: begin
                tmr_en = 1'b1;
                if (expire) begin
                    // Truth index is the vector value, not the step number
                    truth_d[vec_q] = z;
                    if (step_q != LAST_STEP) begin
                        step_d = VEC_W'(step_q + 1'b1);
                        vec_d  = bin2gray(VEC_W'(step_q + 1'b1));
                    end else begin
                        state_d = DONE;
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (truth_d == EXPECT);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            step_q  <= '0;
            truth_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            step_q  <= step_d;
            truth_q <= truth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign {A, B, C, D} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign truth        = truth_q;
    assign mismatch     = truth_q ^ EXPECT;

endmodule

// File: tb/tb_gray_vector_sequencer.sv
// Directed bench for gray_vector_sequencer: one DWELL=20 instance with a
// combinational function model, one DWELL=2 instance with a registered model.
module tb_gray_vector_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance a: DWELL=20, z = xor or and depending on mode_a
    logic        rst_a, start_a, mode_a;
    logic        a_A, a_B, a_C, a_D, z_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] truth_a, mism_a;

    // Instance b: DWELL=2, z registered one cycle behind the vector
    logic        rst_b, start_b;
    logic        b_A, b_B, b_C, b_D, z_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] truth_b, mism_b;

    gray_vector_sequencer #(.DWELL(20), .EXPECT(16'h6996)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .A(a_A), .B(a_B), .C(a_C), .D(a_D), .z(z_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .truth(truth_a), .mismatch(mism_a)
    );

    gray_vector_sequencer #(.DWELL(2), .EXPECT(16'h6996)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .A(b_A), .B(b_B), .C(b_C), .D(b_D), .z(z_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .truth(truth_b), .mismatch(mism_b)
    );

    assign z_a = mode_a ? (a_A & a_B) : (a_A ^ a_B ^ a_C ^ a_D);

    always_ff @(posedge clk) z_b <= b_A ^ b_B ^ b_C ^ b_D;

    logic [3:0] gseq [16];
    logic [3:0] prev_vec;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; mode_a = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_vec_a",   16'({a_A, a_B, a_C, a_D}), 16'h0);
        chk("rst_flags_a", 16'({busy_a, done_a, pass_a}), 16'h0);
        chk("rst_truth_a", truth_a, 16'h0);
        chk("rst_flags_b", 16'({busy_b, done_b, pass_b}), 16'h0);

        // Sweep 1: xor model, extra start at E0+50 must be ignored
        rst_a = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("s1_busy_k0", 16'({busy_a, done_a}), 16'b10);
        chk("s1_vec_k0",  16'({a_A, a_B, a_C, a_D}), 16'h0);
        repeat (49) @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (269) @(negedge clk);
        chk("s1_k319_busy_done", 16'({busy_a, done_a}), 16'b10);
        @(negedge clk);
        chk("s1_k320_busy_done", 16'({busy_a, done_a}), 16'b01);
        chk("s1_truth",    truth_a, 16'h6996);
        chk("s1_pass",     16'(pass_a), 16'h1);
        chk("s1_mismatch", mism_a, 16'h0);
        chk("s1_vec_done", 16'({a_A, a_B, a_C, a_D}), 16'h0);

        // Sweep 2: and model, restarted from DONE
        mode_a = 1'b1; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("s2_k0_flags", 16'({busy_a, done_a, pass_a}), 16'b100);
        repeat (320) @(negedge clk);
        chk("s2_done",     16'(done_a), 16'h1);
        chk("s2_truth",    truth_a, 16'hF000);
        chk("s2_pass",     16'(pass_a), 16'h0);
        chk("s2_mismatch", mism_a, 16'h9996);

        // Sweep 3: reset at E0+100 between edges, then start held through release
        mode_a = 1'b0; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (100) @(negedge clk);
        chk("s3_partial_truth", truth_a, 16'h0006);
        chk("s3_vec_k100", 16'({a_A, a_B, a_C, a_D}), 16'h7);
        rst_a = 1'b1;
        #1;
        chk("s3_rst_vec",   16'({a_A, a_B, a_C, a_D}), 16'h0);
        chk("s3_rst_flags", 16'({busy_a, done_a, pass_a}), 16'h0);
        chk("s3_rst_truth", truth_a, 16'h0);
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk); start_a = 1'b0;
        chk("s3_release_busy", 16'(busy_a), 16'h1);
        repeat (319) @(negedge clk);
        chk("s3_k319_done", 16'(done_a), 16'h0);
        @(negedge clk);
        chk("s3_done",  16'(done_a), 16'h1);
        chk("s3_truth", truth_a, 16'h6996);
        chk("s3_pass",  16'(pass_a), 16'h1);

        // Instance b: Gray order, registered z, start held high
        rst_b = 1'b0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk);
        prev_vec = 4'h0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("gray_vec_%0d", i), 16'({b_A, b_B, b_C, b_D}), 16'(gseq[i]));
            if (i > 0)
                chk($sformatf("gray_onebit_%0d", i),
                    16'($countones({b_A, b_B, b_C, b_D} ^ prev_vec)), 16'h1);
            prev_vec = {b_A, b_B, b_C, b_D};
            repeat (2) @(negedge clk);
        end
        chk("b_done_k32",  16'({busy_b, done_b}), 16'b01);
        chk("b_vec_k32",   16'({b_A, b_B, b_C, b_D}), 16'h0);
        chk("b_truth_1",   truth_b, 16'h6996);
        chk("b_pass_1",    16'(pass_b), 16'h1);
        @(negedge clk);
        chk("b_restart_k33", 16'({busy_b, done_b}), 16'b10);
        repeat (31) @(negedge clk);
        chk("b_k64_done", 16'(done_b), 16'h0);
        @(negedge clk);
        chk("b_k65_done", 16'(done_b), 16'h1);
        chk("b_truth_2",  truth_b, 16'h6996);
        chk("b_pass_2",   16'(pass_b), 16'h1);
        start_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
